// File: rtl/comp_filter_pkg.sv
// Shared definitions for the CIC compensation FIR coefficient controller.
//   COEFF_WIDTH_DEF : default coefficient width (signed Q1.15)
//   COEFF_PRESET    : 8-entry reset/preset pattern, repeated modulo 8 for wider filters
//   coeff_state_e   : controller FSM states
package comp_filter_pkg;

  localparam int COEFF_WIDTH_DEF = 16;

  localparam logic [15:0] COEFF_PRESET [0:7] = '{
    16'h1000, 16'h0F00, 16'h0E00, 16'h0D00,
    16'h0D00, 16'h0E00, 16'h0F00, 16'h1000
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } coeff_state_e;

endpackage

// File: rtl/comp_coeff_bank.sv
// TAPS x COEFF_WIDTH coefficient register bank.
//   clk, rst_n : clock, synchronous active-low reset (loads presets)
//   wr_mask    : per-tap write enables, all enabled taps take wr_data
//   wr_data    : coefficient value to write
//   load_en    : bulk load of every tap from load_data (wins over wr_mask)
//   load_data  : flattened source bank, tap k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   q          : flattened bank contents, same layout
module comp_coeff_bank
  import comp_filter_pkg::*;
#(
  parameter int TAPS        = 8,
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TAPS-1:0]             wr_mask,
  input  logic [COEFF_WIDTH-1:0]      wr_data,
  input  logic                        load_en,
  input  logic [TAPS*COEFF_WIDTH-1:0] load_data,
  output logic [TAPS*COEFF_WIDTH-1:0] q
);

  logic [TAPS-1:0][COEFF_WIDTH-1:0] mem;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    always_ff @(posedge clk) begin
      if (!rst_n)           mem[k] <= COEFF_WIDTH'(COEFF_PRESET[k % 8]);
      else if (load_en)     mem[k] <= load_data[k*COEFF_WIDTH +: COEFF_WIDTH];
      else if (wr_mask[k])  mem[k] <= wr_data;
    end
  end

  assign q = mem;

endmodule

// File: rtl/compensation_coeff_ctrl.sv
// Double-buffered coefficient controller for the CIC compensation FIR.
// The host fills a shadow bank, then commits; the shadow is copied into the
// active bank on the first sample-quiet cycle (data_valid_in=0) or, failing
// that, after SWAP_TIMEOUT cycles of waiting (forced swap).
//   clk, rst_n    : clock, synchronous active-low reset
//   data_valid_in : FIR sample strobe, monitored only
//   cfg_wr_en/cfg_addr/cfg_wdata : shadow write port
//   cfg_commit    : request shadow -> active swap
//   cfg_busy      : swap pending or in progress
//   cfg_err       : one-cycle pulse for a rejected write/commit
//   coeff_out     : active bank, tap k at [k*COEFF_WIDTH +: COEFF_WIDTH]
//   coeff_update  : pulse on the first cycle new coeff_out is visible
//   swap_forced   : pulse with coeff_update when the swap was a timeout
//   bank_seq      : completed swap count (wraps)
// Optional build macro COMP_COEFF_SYMMETRY_EN: symmetric coefficients; a write
// to k < TAPS/2 also updates tap TAPS-1-k, upper addresses are rejected.
module compensation_coeff_ctrl
  import comp_filter_pkg::*;
#(
  parameter int COEFF_WIDTH  = COEFF_WIDTH_DEF,
  parameter int TAPS         = 8,
  parameter int SWAP_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_valid_in,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(TAPS)-1:0]     cfg_addr,
  input  logic [COEFF_WIDTH-1:0]      cfg_wdata,
  input  logic                        cfg_commit,
  output logic                        cfg_busy,
  output logic                        cfg_err,
  output logic [TAPS*COEFF_WIDTH-1:0] coeff_out,
  output logic                        coeff_update,
  output logic                        swap_forced,
  output logic [7:0]                  bank_seq
);

  localparam int CW = $clog2(SWAP_TIMEOUT + 1);

  coeff_state_e            state, state_nxt;
  logic [CW-1:0]           wait_cnt;
  logic                    forced_q;
  logic                    timeout;
  logic                    addr_ok;
  logic                    wr_ok;
  logic [TAPS-1:0]         wr_mask;
  logic                    load_en;
  logic                    busy_d, err_d, update_d, forced_d;
  logic [TAPS*COEFF_WIDTH-1:0] shadow_q;

  // Last PENDING cycle once wait_cnt has counted SWAP_TIMEOUT-1 earlier cycles.
  assign timeout = (wait_cnt == CW'(SWAP_TIMEOUT - 1));

`ifdef COMP_COEFF_SYMMETRY_EN
  // TAPS is a power of two, so addr < TAPS/2 is simply a clear MSB,
  // and the mirrored tap TAPS-1-k is the bitwise complement of k.
  assign addr_ok = !cfg_addr[$clog2(TAPS)-1];
  always_comb begin
    wr_mask = '0;
    if (wr_ok) begin
      wr_mask[cfg_addr]  = 1'b1;
      wr_mask[~cfg_addr] = 1'b1;
    end
  end
`else
  assign addr_ok = 1'b1;
  always_comb begin
    wr_mask = '0;
    if (wr_ok) wr_mask[cfg_addr] = 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_commit) state_nxt = PENDING;
      PENDING: if (!data_valid_in || timeout) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs and bank controls)
  always_comb begin
    wr_ok    = (state == IDLE) && cfg_wr_en && addr_ok;
    load_en  = (state == SWAP);
    busy_d   = (state_nxt != IDLE);
    err_d    = ((state != IDLE) && (cfg_wr_en || cfg_commit)) ||
               ((state == IDLE) && cfg_wr_en && !addr_ok);
    update_d = (state == SWAP);
    forced_d = (state == SWAP) && forced_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      forced_q     <= 1'b0;
      cfg_busy     <= 1'b0;
      cfg_err      <= 1'b0;
      coeff_update <= 1'b0;
      swap_forced  <= 1'b0;
      bank_seq     <= 8'd0;
    end else begin
      wait_cnt     <= (state == PENDING) ? wait_cnt + 1'b1 : '0;
      // A quiet cycle wins over timeout: only flag forced if data was still valid.
      if (state == PENDING)   forced_q <= data_valid_in && timeout;
      else if (state == SWAP) forced_q <= 1'b0;
      cfg_busy     <= busy_d;
      cfg_err      <= err_d;
      coeff_update <= update_d;
      swap_forced  <= forced_d;
      if (state == SWAP) bank_seq <= bank_seq + 8'd1;
    end
  end

  comp_coeff_bank #(.TAPS(TAPS), .COEFF_WIDTH(COEFF_WIDTH)) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_mask   (wr_mask),
    .wr_data   (cfg_wdata),
    .load_en   (1'b0),
    .load_data ('0),
    .q         (shadow_q)
  );

  comp_coeff_bank #(.TAPS(TAPS), .COEFF_WIDTH(COEFF_WIDTH)) u_active (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_mask   ('0),
    .wr_data   ('0),
    .load_en   (load_en),
    .load_data (shadow_q),
    .q         (coeff_out)
  );

endmodule

// File: tb/tb_compensation_coeff_ctrl.sv
module tb_compensation_coeff_ctrl;
  localparam int W  = 16;
  localparam int T  = 8;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           data_valid_in;
  logic           cfg_wr_en;
  logic [2:0]     cfg_addr;
  logic [W-1:0]   cfg_wdata;
  logic           cfg_commit;
  logic           cfg_busy, cfg_err, coeff_update, swap_forced;
  logic [T*W-1:0] coeff_out;
  logic [7:0]     bank_seq;

  int n_chk  = 0;
  int n_fail = 0;

  compensation_coeff_ctrl #(.COEFF_WIDTH(W), .TAPS(T), .SWAP_TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_valid_in (data_valid_in),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_commit    (cfg_commit),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .coeff_out     (coeff_out),
    .coeff_update  (coeff_update),
    .swap_forced   (swap_forced),
    .bank_seq      (bank_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] tap(input int k);
    return coeff_out[k*W +: W];
  endfunction

  initial begin
    rst_n = 1'b0; data_valid_in = 1'b0; cfg_wr_en = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_tap0", 32'(tap(0)), 32'h1000);
    chk("rst_tap3", 32'(tap(3)), 32'h0D00);
    chk("rst_tap6", 32'(tap(6)), 32'h0F00);
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_upd", 32'(coeff_update), 0);
    chk("rst_forced", 32'(swap_forced), 0);
    chk("rst_seq", 32'(bank_seq), 0);

    // Write tap2, quiet commit: update three cycles after commit edge
    cfg_wr_en = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'h7FFF;
    tick();
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("q_busy1", 32'(cfg_busy), 1);
    chk("q_upd1", 32'(coeff_update), 0);
    chk("q_tap2_old", 32'(tap(2)), 32'h0E00);
    tick();
    chk("q_busy2", 32'(cfg_busy), 1);
    chk("q_upd2", 32'(coeff_update), 0);
    tick();
    chk("q_upd3", 32'(coeff_update), 1);
    chk("q_forced", 32'(swap_forced), 0);
    chk("q_tap2", 32'(tap(2)), 32'h7FFF);
    chk("q_tap1", 32'(tap(1)), 32'h0F00);
    chk("q_tap7", 32'(tap(7)), 32'h1000);
    chk("q_seq", 32'(bank_seq), 1);
    chk("q_busy3", 32'(cfg_busy), 0);
    tick();
    chk("q_upd_pulse", 32'(coeff_update), 0);

    // Forced swap with data_valid held high; rejected strobes while pending
    data_valid_in = 1'b1; cfg_commit = 1'b1;
    tick();                                   // cycle N+1
    cfg_commit = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'h1234;
    chk("f_upd1", 32'(coeff_update), 0);
    tick();                                   // N+2
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    chk("f_err_wr", 32'(cfg_err), 1);
    chk("f_upd2", 32'(coeff_update), 0);
    tick();                                   // N+3
    cfg_commit = 1'b0;
    chk("f_err_cm", 32'(cfg_err), 1);
    chk("f_upd3", 32'(coeff_update), 0);
    tick();                                   // N+4
    chk("f_err_clr", 32'(cfg_err), 0);
    chk("f_busy4", 32'(cfg_busy), 1);
    tick();                                   // N+5 (SWAP)
    chk("f_upd5", 32'(coeff_update), 0);
    chk("f_busy5", 32'(cfg_busy), 1);
    tick();                                   // N+6
    chk("f_upd6", 32'(coeff_update), 1);
    chk("f_forced", 32'(swap_forced), 1);
    chk("f_tap2_kept", 32'(tap(2)), 32'h7FFF);
    chk("f_seq", 32'(bank_seq), 2);
    tick();
    chk("f_forced_pulse", 32'(swap_forced), 0);
    data_valid_in = 1'b0;

    // Write + commit in the same IDLE cycle: the write is included
    cfg_wr_en = 1'b1; cfg_commit = 1'b1; cfg_addr = 3'd0; cfg_wdata = 16'h0123;
    tick();
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    chk("wc_err", 32'(cfg_err), 0);
    tick(); tick();
    chk("wc_upd", 32'(coeff_update), 1);
    chk("wc_tap0", 32'(tap(0)), 32'h0123);
    chk("wc_seq", 32'(bank_seq), 3);

    // Reset mid-PENDING aborts the swap and restores presets
    tick();
    cfg_wr_en = 1'b1; cfg_addr = 3'd4; cfg_wdata = 16'h5555;
    tick();
    cfg_wr_en = 1'b0; data_valid_in = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("r_busy_pend", 32'(cfg_busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("r_busy", 32'(cfg_busy), 0);
    chk("r_upd", 32'(coeff_update), 0);
    chk("r_tap0", 32'(tap(0)), 32'h1000);
    chk("r_tap4", 32'(tap(4)), 32'h0D00);
    chk("r_seq", 32'(bank_seq), 0);
    data_valid_in = 1'b0;
    tick(); tick(); tick();
    chk("r_no_upd", 32'(coeff_update), 0);
    chk("r_tap2", 32'(tap(2)), 32'h0E00);

    // Bare commit after reset re-applies the restored preset shadow
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    chk("b_upd", 32'(coeff_update), 1);
    chk("b_tap4", 32'(tap(4)), 32'h0D00);
    chk("b_tap2", 32'(tap(2)), 32'h0E00);
    chk("b_seq", 32'(bank_seq), 1);
    tick();

`ifdef COMP_COEFF_SYMMETRY_EN
    cfg_wr_en = 1'b1; cfg_addr = 3'd1; cfg_wdata = 16'h0ABC;
    tick();
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    chk("s_err_ok", 32'(cfg_err), 0);
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    chk("s_upd", 32'(coeff_update), 1);
    chk("s_tap1", 32'(tap(1)), 32'h0ABC);
    chk("s_tap6", 32'(tap(6)), 32'h0ABC);
    chk("s_tap5", 32'(tap(5)), 32'h0E00);
    cfg_wr_en = 1'b1; cfg_addr = 3'd5; cfg_wdata = 16'h4444;
    tick();
    cfg_wr_en = 1'b0;
    chk("s_err_hi", 32'(cfg_err), 1);
    tick();
    chk("s_err_clr", 32'(cfg_err), 0);
`else
    cfg_wr_en = 1'b1; cfg_addr = 3'd5; cfg_wdata = 16'h0ABC;
    tick();
    cfg_wr_en = 1'b0; cfg_commit = 1'b1;
    chk("i_err", 32'(cfg_err), 0);
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    chk("i_upd", 32'(coeff_update), 1);
    chk("i_tap5", 32'(tap(5)), 32'h0ABC);
    chk("i_tap2", 32'(tap(2)), 32'h0E00);
    chk("i_tap4", 32'(tap(4)), 32'h0D00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/compensation_coeff_ctrl.md
# compensation_coeff_ctrl

Double-buffered coefficient controller for the CIC compensation FIR. A host writes a shadow coefficient bank through a simple register port, then commits it. The controller swaps the shadow bank into the active bank only on a sample-quiet cycle, or by force after a timeout. The active bank drives the FIR coefficient inputs, so coefficient changes never land mid-sample.

## Interface
- COEFF_WIDTH, 16, coefficient width in bits (signed Q1.15)
- TAPS, 8, number of FIR taps; must be even and a power of two
- SWAP_TIMEOUT, 255, maximum PENDING cycles before a forced swap; must be ≥ 1
- clk  in  1  processing clock, shared with the FIR
- rst_n  in  1  reset; synchronous, active-low
- data_valid_in  in  1  sample strobe presented to the FIR; monitored only, never gated
- cfg_wr_en  in  1  shadow write strobe
- cfg_addr  in  $clog2(TAPS)  shadow tap index
- cfg_wdata  in  COEFF_WIDTH  coefficient value
- cfg_commit  in  1  request to swap shadow into active
- cfg_busy  out  1  high in PENDING and SWAP
- cfg_err  out  1  one-cycle pulse on a rejected write or commit
- coeff_out  out  TAPS*COEFF_WIDTH  active bank; tap k is at [k*COEFF_WIDTH +: COEFF_WIDTH]
- coeff_update  out  1  one-cycle pulse on the first cycle new coeff_out is visible
- swap_forced  out  1  one-cycle pulse coincident with coeff_update when the swap was caused by timeout
- bank_seq  out  8  count of completed swaps, wraps 255→0

## Operation
- States: IDLE, PENDING, SWAP.
- IDLE
  - cfg_wr_en writes cfg_wdata to shadow[cfg_addr].
  - cfg_commit moves the FSM to PENDING.
  - If cfg_wr_en and cfg_commit are both high in the same cycle, the write is applied and the commit includes it.
- PENDING
  - Any cfg_wr_en or cfg_commit is dropped and pulses cfg_err; shadow is unchanged.
  - The wait counter increments each cycle.
  - The FSM goes to SWAP on the first cycle with data_valid_in=0, or when the counter reaches SWAP_TIMEOUT. In the timeout case the swap is flagged as forced.
- SWAP (one cycle)
  - active ← shadow.
  - bank_seq increments.
  - Wait counter clears.
  - coeff_update (and swap_forced if flagged) are registered.
  - FSM returns to IDLE.
- Inputs during SWAP are handled as in PENDING: dropped, with a cfg_err pulse.
- Shadow persists after a swap, so a bare commit re-applies the same bank.
- Reset and presets: both banks load the preset {0x1000, 0x0F00, 0x0E00, 0x0D00, 0x0D00, 0x0E00, 0x0F00, 0x1000}. For TAPS≠8, the pattern repeats modulo 8.
- Reset mid-operation aborts PENDING/SWAP without a swap and restores the presets.
- Coefficients are stored and driven unmodified; there is no arithmetic on coefficient values.

## Timing
- Reset values:
  - cfg_busy=0, cfg_err=0, coeff_update=0, swap_forced=0, bank_seq=0.
  - coeff_out = presets.
  - FSM in IDLE, wait counter = 0.
- All outputs are registered.
- Write latency: shadow is updated at the clock edge that samples cfg_wr_en. Shadow is not externally visible.
- Commit latency, no traffic:
  - Commit sampled at edge N.
  - PENDING during cycle N+1.
  - SWAP during N+2.
  - New coeff_out and coeff_update=1 in N+3.
  - cfg_busy is high in N+1..N+2.
- Forced swap under continuous data_valid_in: PENDING lasts SWAP_TIMEOUT cycles, then SWAP, and coeff_update arrives SWAP_TIMEOUT+2 cycles after the commit edge.
- cfg_err asserts in the cycle after the offending strobe.

## Configuration
- COMP_COEFF_SYMMETRY_EN defined:
  - The shadow holds only TAPS/2 unique coefficients.
  - A write to address k<TAPS/2 updates both taps k and TAPS-1-k.
  - A write with cfg_addr≥TAPS/2 is dropped and pulses cfg_err.
- Undefined: every address is written independently and all addresses are legal.

## Structure
- Package comp_filter_pkg holds:
  - the COEFF_WIDTH default;
  - the 8-entry preset constant array;
  - the state enum (IDLE/PENDING/SWAP).
- One sub-module, comp_coeff_bank: TAPS×COEFF_WIDTH register array with a write port, a synchronous preset load on reset, and a flattened read output. It is instantiated twice (shadow and active); the active instance has a bulk-load input from the shadow.

## Test plan
- Reset, then idle: coeff_out tap0=0x1000, tap3=0x0D00; all pulses 0; bank_seq=0.
- Write tap2=0x7FFF, commit at edge N with data_valid_in=0 → coeff_update at N+3, tap2=0x7FFF, other taps preset, bank_seq=1.
- Commit with data_valid_in held high and SWAP_TIMEOUT=4 → swap_forced and coeff_update together, 6 cycles after the commit edge.
- Write or commit during PENDING → cfg_err pulse; after the swap, shadow still holds the pre-commit value.
- rst_n low mid-PENDING → no coeff_update, coeff_out stays preset, cfg_busy=0 on the next cycle.
- With COMP_COEFF_SYMMETRY_EN: write addr1=0x0ABC → taps 1 and 6 both 0x0ABC after the swap; write addr5 → cfg_err.
